tcp_tx_pkt_serializer: RTL and testbench
========================================

Name: tcp_tx_pkt_serializer

Overview:
- Converts the TCP engine's transmit descriptor into a flit stream for the Ethernet/IP framing stage.
- The descriptor is source IP, destination IP, 160-bit TCP header, payload buffer address and length.
- Emits four header flits, then fetches the payload from the payload buffer one word at a time and forwards it as data flits.
- It is the transmit-side counterpart to the receive parser that feeds the engine's header/payload inputs.

Parameters:
- DATA_W, 64, output flit and payload buffer word width in bits; fixed at 64 (8 bytes).
- PAYLOAD_ADDR_W, 32, payload buffer byte address width.
- PAYLOAD_LEN_W, 16, payload length width in bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tcp_ser_val  in  1  descriptor valid.
- ser_tcp_rdy  out  1  descriptor ready.
- tcp_ser_src_ip  in  32  source IP.
- tcp_ser_dst_ip  in  32  destination IP.
- tcp_ser_tcp_hdr  in  160  TCP header, no options.
- tcp_ser_payload_addr  in  PAYLOAD_ADDR_W  payload byte address, 8-byte aligned.
- tcp_ser_payload_len  in  PAYLOAD_LEN_W  payload bytes; 0 = header only.
- ser_buf_rd_req_val  out  1  payload read request valid.
- buf_ser_rd_req_rdy  in  1  request ready.
- ser_buf_rd_req_addr  out  PAYLOAD_ADDR_W  word byte address.
- buf_ser_rd_resp_val  in  1  read data valid.
- ser_buf_rd_resp_rdy  out  1  read data ready.
- buf_ser_rd_resp_data  in  DATA_W  read data.
- ser_out_val  out  1  flit valid.
- out_ser_rdy  in  1  flit ready.
- ser_out_data  out  DATA_W  flit.
- ser_out_last  out  1  last flit of packet.
- ser_out_padbytes  out  3  invalid low-order bytes in the last flit; 0 when not last.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; all counters and registers zero.
  - ser_tcp_rdy=1; ser_out_val, ser_buf_rd_req_val, ser_buf_rd_resp_rdy, ser_out_last and ser_out_padbytes all 0.
  - Reset mid-packet abandons the packet immediately, with no further flits or requests. Any outstanding read response is the buffer's concern; the buffer is reset together with this block.
- Handshake rules:
  - A transfer occurs when val&&rdy on a rising clk edge.
  - Outputs are registered-state driven. While val=1 and rdy=0, data, last and padbytes hold stable.
- States:
  - IDLE:
    - ser_tcp_rdy=1.
    - On accept: register all descriptor fields, hdr_cnt=0, words_left=ceil(len/8), addr register = payload_addr. Go to HDR.
  - HDR:
    - ser_out_val=1, ser_tcp_rdy=0.
    - Flit by hdr_cnt, with byte 0 in bits [63:56]:
      - 0: {src_ip, dst_ip}
      - 1: tcp_hdr[159:96]
      - 2: tcp_hdr[95:32]
      - 3: {tcp_hdr[31:0], 32'h0}
    - On out handshake: hdr_cnt++.
    - At hdr_cnt=3: if words_left=0, last=1 and padbytes=4, then go to IDLE. Otherwise last=0 and go to PL_REQ.
    - First header flit appears the cycle after the descriptor is accepted.
  - PL_REQ:
    - ser_buf_rd_req_val=1 with the addr register.
    - On request handshake: addr += 8 (wraps modulo 2^PAYLOAD_ADDR_W). Go to PL_RESP.
  - PL_RESP:
    - ser_out_val = buf_ser_rd_resp_val and ser_buf_rd_resp_rdy = out_ser_rdy, combinational pass-through (the only combinational path). ser_out_data = buf_ser_rd_resp_data.
    - Last word: last=1 and padbytes=(8 - len%8)%8. The block does not mask pad bytes.
    - On resp handshake: words_left--. If 0, go to IDLE; else go to PL_REQ.
- Concurrency and arithmetic:
  - Exactly one read outstanding at any time.
  - A new descriptor is accepted only in IDLE, so the earliest next accept is the cycle after the last flit handshake.
  - words_left width is PAYLOAD_LEN_W-2; len=65535 gives 8192 words.
- Response with no request: a response arriving in any state other than PL_RESP is a protocol error. ser_buf_rd_resp_rdy=0 outside PL_RESP, and the response is not consumed.

Test Plan:
- len=0, src=0x0A000001, dst=0x0A000002, hdr=160'h1 -> exactly 4 flits: 0x0A0000010A000002, 0, 0, 0x0000000100000000; last on flit 4, padbytes=4; no read requests.
- len=8, addr=0x100, buffer word 0xDEADBEEFCAFEF00D -> 5 flits; one request at 0x100; flit 5 = that word, last=1, padbytes=0.
- len=13, addr=0x200 -> requests at 0x200 and 0x208; 6 flits; last flit padbytes=3; ser_tcp_rdy stays 0 until the last handshake.
- out_ser_rdy toggled 1/0 every cycle during len=24 -> output flit sequence identical to the rdy=1 run; data, last and padbytes stable through stalls; no duplicated or dropped flits.
- addr=0xFFFFFFF8, len=16 -> requests at 0xFFFFFFF8 then 0x00000000.
- rst_n asserted during the payload's second word -> next cycle all outputs at reset values. A new descriptor after reset produces a complete correct packet starting with the header flit for src/dst.

Source files
------------

// File: rtl/tcp_tx_pkt_serializer.sv
// Purpose: serialize a TCP transmit descriptor into 4 header flits followed by payload words fetched from the buffer.
// Latency: first header flit the cycle after descriptor accept; each payload word costs a request cycle plus the buffer's response time.
// Backpressure: output stalls hold flit/last/padbytes; payload response ready passes out_ser_rdy straight through.
module tcp_tx_pkt_serializer #(
  parameter int DATA_W         = 64,
  parameter int PAYLOAD_ADDR_W = 32,
  parameter int PAYLOAD_LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tcp_ser_val,
  output logic                      ser_tcp_rdy,
  input  logic [31:0]               tcp_ser_src_ip,
  input  logic [31:0]               tcp_ser_dst_ip,
  input  logic [159:0]              tcp_ser_tcp_hdr,
  input  logic [PAYLOAD_ADDR_W-1:0] tcp_ser_payload_addr,
  input  logic [PAYLOAD_LEN_W-1:0]  tcp_ser_payload_len,
  output logic                      ser_buf_rd_req_val,
  input  logic                      buf_ser_rd_req_rdy,
  output logic [PAYLOAD_ADDR_W-1:0] ser_buf_rd_req_addr,
  input  logic                      buf_ser_rd_resp_val,
  output logic                      ser_buf_rd_resp_rdy,
  input  logic [DATA_W-1:0]         buf_ser_rd_resp_data,
  output logic                      ser_out_val,
  input  logic                      out_ser_rdy,
  output logic [DATA_W-1:0]         ser_out_data,
  output logic                      ser_out_last,
  output logic [2:0]                ser_out_padbytes
);

  // 14 bits is enough for 8192 words (len = 65535 rounds up to 8192).
  localparam int WL_W = PAYLOAD_LEN_W - 2;

  typedef enum logic [1:0] {IDLE, HDR, PL_REQ, PL_RESP} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               src_ip_q;
  logic [31:0]               dst_ip_q;
  logic [159:0]              tcp_hdr_q;
  logic [PAYLOAD_ADDR_W-1:0] addr_q;
  logic [WL_W-1:0]           words_left_q;
  logic [2:0]                pad_q;
  logic [1:0]                hdr_cnt_q;
  logic [WL_W-1:0]           words_init;

  // ceil(len/8): whole words plus one more if any tail bytes remain.
  assign words_init = WL_W'({1'b0, tcp_ser_payload_len[PAYLOAD_LEN_W-1:3]})
                    + WL_W'(|tcp_ser_payload_len[2:0]);

  // The read address is only qualified by ser_buf_rd_req_val.
  assign ser_buf_rd_req_addr = addr_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Descriptor capture, header flit counter, read address and word countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      tcp_hdr_q    <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      pad_q        <= '0;
      hdr_cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: if (tcp_ser_val) begin
          src_ip_q     <= tcp_ser_src_ip;
          dst_ip_q     <= tcp_ser_dst_ip;
          tcp_hdr_q    <= tcp_ser_tcp_hdr;
          addr_q       <= tcp_ser_payload_addr;
          words_left_q <= words_init;
          // (8 - len%8) % 8 is just the negated low three bits.
          pad_q        <= 3'd0 - tcp_ser_payload_len[2:0];
          hdr_cnt_q    <= '0;
        end
        HDR: if (out_ser_rdy) hdr_cnt_q <= hdr_cnt_q + 2'd1;
        PL_REQ: if (buf_ser_rd_req_rdy) addr_q <= addr_q + PAYLOAD_ADDR_W'(8);
        PL_RESP: if (buf_ser_rd_resp_val && out_ser_rdy) words_left_q <= words_left_q - WL_W'(1);
        default: ;
      endcase
    end
  end

  // Next-state and output decode; PL_RESP passes the buffer response straight to the output.
  always_comb begin
    state_nxt           = state;
    ser_tcp_rdy         = 1'b0;
    ser_out_val         = 1'b0;
    ser_out_data        = '0;
    ser_out_last        = 1'b0;
    ser_out_padbytes    = 3'd0;
    ser_buf_rd_req_val  = 1'b0;
    ser_buf_rd_resp_rdy = 1'b0;
    case (state)
      IDLE: begin
        ser_tcp_rdy = 1'b1;
        if (tcp_ser_val) state_nxt = HDR;
      end
      HDR: begin
        ser_out_val = 1'b1;
        case (hdr_cnt_q)
          2'd0:    ser_out_data = {src_ip_q, dst_ip_q};
          2'd1:    ser_out_data = tcp_hdr_q[159:96];
          2'd2:    ser_out_data = tcp_hdr_q[95:32];
          default: ser_out_data = {tcp_hdr_q[31:0], 32'h0};
        endcase
        if (hdr_cnt_q == 2'd3 && words_left_q == '0) begin
          // Header-only packet: the last flit carries 4 unused zero bytes.
          ser_out_last     = 1'b1;
          ser_out_padbytes = 3'd4;
        end
        if (out_ser_rdy && hdr_cnt_q == 2'd3)
          state_nxt = (words_left_q == '0) ? IDLE : PL_REQ;
      end
      PL_REQ: begin
        ser_buf_rd_req_val = 1'b1;
        if (buf_ser_rd_req_rdy) state_nxt = PL_RESP;
      end
      PL_RESP: begin
        ser_out_val         = buf_ser_rd_resp_val;
        ser_buf_rd_resp_rdy = out_ser_rdy;
        ser_out_data        = buf_ser_rd_resp_data;
        if (words_left_q == WL_W'(1)) begin
          ser_out_last     = 1'b1;
          ser_out_padbytes = pad_q;
        end
        if (buf_ser_rd_resp_val && out_ser_rdy)
          state_nxt = (words_left_q == WL_W'(1)) ? IDLE : PL_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tcp_tx_pkt_serializer.sv
// Directed bench for tcp_tx_pkt_serializer with a scoreboard of expected flits and read addresses.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Includes a one-read-outstanding payload buffer model and an optional toggling output ready.
module tb_tcp_tx_pkt_serializer;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  pad;
  } flit_t;

  logic         clk;
  logic         rst_n;
  logic         tcp_ser_val;
  logic         ser_tcp_rdy;
  logic [31:0]  tcp_ser_src_ip;
  logic [31:0]  tcp_ser_dst_ip;
  logic [159:0] tcp_ser_tcp_hdr;
  logic [31:0]  tcp_ser_payload_addr;
  logic [15:0]  tcp_ser_payload_len;
  logic         ser_buf_rd_req_val;
  logic         buf_ser_rd_req_rdy;
  logic [31:0]  ser_buf_rd_req_addr;
  logic         buf_ser_rd_resp_val;
  logic         ser_buf_rd_resp_rdy;
  logic [63:0]  buf_ser_rd_resp_data;
  logic         ser_out_val;
  logic         out_ser_rdy;
  logic [63:0]  ser_out_data;
  logic         ser_out_last;
  logic [2:0]   ser_out_padbytes;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_flits  = 0;
  bit           toggle_en = 0;
  flit_t        exp_q[$];
  logic [31:0]  req_q[$];
  logic [63:0]  mem [logic [31:0]];

  tcp_tx_pkt_serializer #(.DATA_W(64), .PAYLOAD_ADDR_W(32), .PAYLOAD_LEN_W(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .tcp_ser_val          (tcp_ser_val),
    .ser_tcp_rdy          (ser_tcp_rdy),
    .tcp_ser_src_ip       (tcp_ser_src_ip),
    .tcp_ser_dst_ip       (tcp_ser_dst_ip),
    .tcp_ser_tcp_hdr      (tcp_ser_tcp_hdr),
    .tcp_ser_payload_addr (tcp_ser_payload_addr),
    .tcp_ser_payload_len  (tcp_ser_payload_len),
    .ser_buf_rd_req_val   (ser_buf_rd_req_val),
    .buf_ser_rd_req_rdy   (buf_ser_rd_req_rdy),
    .ser_buf_rd_req_addr  (ser_buf_rd_req_addr),
    .buf_ser_rd_resp_val  (buf_ser_rd_resp_val),
    .ser_buf_rd_resp_rdy  (ser_buf_rd_resp_rdy),
    .buf_ser_rd_resp_data (buf_ser_rd_resp_data),
    .ser_out_val          (ser_out_val),
    .out_ser_rdy          (out_ser_rdy),
    .ser_out_data         (ser_out_data),
    .ser_out_last         (ser_out_last),
    .ser_out_padbytes     (ser_out_padbytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer contents: explicit entries, otherwise {addr, ~addr}.
  function automatic logic [63:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a};
  endfunction

  // Payload buffer: returns the word the cycle after a request is accepted, holds it until taken.
  initial begin
    bit          req_hs;
    bit          resp_hs;
    logic [31:0] a_s;
    buf_ser_rd_resp_val  = 1'b0;
    buf_ser_rd_resp_data = '0;
    buf_ser_rd_req_rdy   = 1'b1;
    forever begin
      @(negedge clk);
      req_hs  = rst_n && ser_buf_rd_req_val && buf_ser_rd_req_rdy;
      resp_hs = rst_n && buf_ser_rd_resp_val && ser_buf_rd_resp_rdy;
      a_s     = ser_buf_rd_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) buf_ser_rd_resp_val = 1'b0;
      else begin
        if (resp_hs) buf_ser_rd_resp_val = 1'b0;
        if (req_hs) begin
          buf_ser_rd_resp_val  = 1'b1;
          buf_ser_rd_resp_data = word_at(a_s);
        end
      end
    end
  end

  // Output ready: held high, or toggled every cycle when toggle_en is set.
  initial begin
    out_ser_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ser_rdy = toggle_en ? ~out_ser_rdy : 1'b1;
    end
  end

  // Monitor: checks flits and read requests against the scoreboard, plus stall stability.
  initial begin
    bit    prev_stall = 0;
    flit_t prev_f;
    flit_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_val_held", 64'(ser_out_val), 64'd1);
          chk("stall_data_held", ser_out_data, prev_f.data);
          chk("stall_last_pad_held", 64'({ser_out_last, ser_out_padbytes}), 64'({prev_f.last, prev_f.pad}));
        end
        prev_stall  = ser_out_val && !out_ser_rdy;
        prev_f.data = ser_out_data;
        prev_f.last = ser_out_last;
        prev_f.pad  = ser_out_padbytes;
        if (ser_out_val) chk("tcp_rdy_low_in_packet", 64'(ser_tcp_rdy), 64'd0);
        if (ser_out_val && out_ser_rdy) begin
          n_flits++;
          if (exp_q.size() == 0) begin
            chk("unexpected_flit", ser_out_data, 64'hx);
          end else begin
            e = exp_q.pop_front();
            chk("flit_data", ser_out_data, e.data);
            chk("flit_last", 64'(ser_out_last), 64'(e.last));
            chk("flit_padbytes", 64'(ser_out_padbytes), 64'(e.pad));
          end
        end
        if (ser_buf_rd_req_val && buf_ser_rd_req_rdy) begin
          if (req_q.size() == 0) chk("unexpected_req", 64'(ser_buf_rd_req_addr), 64'hx);
          else chk("req_addr", 64'(ser_buf_rd_req_addr), 64'(req_q.pop_front()));
        end
      end
    end
  end

  task automatic push_flit(input logic [63:0] d, input logic l, input logic [2:0] p);
    flit_t f;
    f.data = d; f.last = l; f.pad = p;
    exp_q.push_back(f);
  endtask

  task automatic push_hdr(input logic [31:0] s, input logic [31:0] d, input logic [159:0] h, input bit hdr_only);
    push_flit({s, d}, 1'b0, 3'd0);
    push_flit(h[159:96], 1'b0, 3'd0);
    push_flit(h[95:32], 1'b0, 3'd0);
    push_flit({h[31:0], 32'h0}, hdr_only, hdr_only ? 3'd4 : 3'd0);
  endtask

  task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [159:0] h,
                           input logic [31:0] a, input logic [15:0] len);
    bit ok = 0;
    @(posedge clk);
    #1;
    tcp_ser_val          = 1'b1;
    tcp_ser_src_ip       = s;
    tcp_ser_dst_ip       = d;
    tcp_ser_tcp_hdr      = h;
    tcp_ser_payload_addr = a;
    tcp_ser_payload_len  = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ser_tcp_rdy) begin ok = 1; break; end
    end
    if (!ok) chk("desc_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    tcp_ser_val = 1'b0;
  endtask

  // Wait for the scoreboard to drain, then confirm the block is back in idle.
  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL %s_timeout: %0d flits still expected", name, exp_q.size());
      n_checks++; n_fail++;
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_idle_rdy"}, 64'(ser_tcp_rdy), 64'd1);
    chk({name, "_reqs_done"}, 64'(req_q.size()), 64'd0);
    req_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tcp_rdy"}, 64'(ser_tcp_rdy), 64'd1);
    chk({name, "_out_val"}, 64'(ser_out_val), 64'd0);
    chk({name, "_req_val"}, 64'(ser_buf_rd_req_val), 64'd0);
    chk({name, "_resp_rdy"}, 64'(ser_buf_rd_resp_rdy), 64'd0);
    chk({name, "_last_pad"}, 64'({ser_out_last, ser_out_padbytes}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n                = 1'b0;
    tcp_ser_val          = 1'b0;
    tcp_ser_src_ip       = '0;
    tcp_ser_dst_ip       = '0;
    tcp_ser_tcp_hdr      = '0;
    tcp_ser_payload_addr = '0;
    tcp_ser_payload_len  = '0;
    mem[32'h100] = 64'hDEADBEEFCAFEF00D;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Header-only packet, hand-computed flits, no reads expected.
    push_flit(64'h0A0000010A000002, 1'b0, 3'd0);
    push_flit(64'h0, 1'b0, 3'd0);
    push_flit(64'h0, 1'b0, 3'd0);
    push_flit(64'h0000000100000000, 1'b1, 3'd4);
    send_desc(32'h0A000001, 32'h0A000002, 160'h1, 32'h0, 16'd0);
    wait_done("len0");

    // One full payload word.
    push_hdr(32'hC0A80001, 32'hC0A80002, 160'h0123456789ABCDEF_FEDCBA9876543210_AABBCCDD, 0);
    push_flit(64'hDEADBEEFCAFEF00D, 1'b1, 3'd0);
    req_q.push_back(32'h100);
    send_desc(32'hC0A80001, 32'hC0A80002, 160'h0123456789ABCDEF_FEDCBA9876543210_AABBCCDD, 32'h100, 16'd8);
    wait_done("len8");

    // 13 bytes: two words, 3 pad bytes in the last.
    push_hdr(32'h11111111, 32'h22222222, {5{32'h33334444}}, 0);
    push_flit(64'h00000200FFFFFDFF, 1'b0, 3'd0);
    push_flit(64'h00000208FFFFFDF7, 1'b1, 3'd3);
    req_q.push_back(32'h200);
    req_q.push_back(32'h208);
    send_desc(32'h11111111, 32'h22222222, {5{32'h33334444}}, 32'h200, 16'd13);
    wait_done("len13");

    // 24 bytes with steady ready, then the same packet with ready toggling.
    for (int pass = 0; pass < 2; pass++) begin
      toggle_en = (pass == 1);
      push_hdr(32'hAAAA0001, 32'hBBBB0002, 160'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 0);
      push_flit(64'h00000400FFFFFBFF, 1'b0, 3'd0);
      push_flit(64'h00000408FFFFFBF7, 1'b0, 3'd0);
      push_flit(64'h00000410FFFFFBEF, 1'b1, 3'd0);
      req_q.push_back(32'h400);
      req_q.push_back(32'h408);
      req_q.push_back(32'h410);
      send_desc(32'hAAAA0001, 32'hBBBB0002, 160'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 32'h400, 16'd24);
      wait_done(pass == 0 ? "len24_rdy1" : "len24_toggle");
    end
    toggle_en = 0;

    // Address wrap at the top of the address space.
    push_hdr(32'h01020304, 32'h05060708, 160'h0, 0);
    push_flit(64'hFFFFFFF800000007, 1'b0, 3'd0);
    push_flit(64'h00000000FFFFFFFF, 1'b1, 3'd0);
    req_q.push_back(32'hFFFFFFF8);
    req_q.push_back(32'h00000000);
    send_desc(32'h01020304, 32'h05060708, 160'h0, 32'hFFFFFFF8, 16'd16);
    wait_done("wrap");

    // Reset while the second payload word is in flight.
    n_flits = 0;
    push_hdr(32'h0A0A0A0A, 32'h0B0B0B0B, 160'h1234, 0);
    push_flit(64'h00000500FFFFFAFF, 1'b0, 3'd0);
    push_flit(64'h00000508FFFFFAF7, 1'b0, 3'd0);
    push_flit(64'h00000510FFFFFAEF, 1'b1, 3'd0);
    req_q.push_back(32'h500);
    req_q.push_back(32'h508);
    req_q.push_back(32'h510);
    send_desc(32'h0A0A0A0A, 32'h0B0B0B0B, 160'h1234, 32'h500, 16'd24);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_flits >= 5) begin ok = 1; break; end
    end
    chk("reset_test_reached_word2", 64'(ok), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    req_q.delete();
    @(negedge clk);
    chk_reset_outputs("midpkt_reset");
    repeat (2) @(negedge clk);
    chk_reset_outputs("midpkt_reset_held");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Fresh packet after reset.
    push_hdr(32'hCAFE0001, 32'hBEEF0002, 160'h9, 0);
    push_flit(64'h00000600FFFFF9FF, 1'b1, 3'd0);
    req_q.push_back(32'h600);
    send_desc(32'hCAFE0001, 32'hBEEF0002, 160'h9, 32'h600, 16'd8);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
